e203_itcm_icb_arbt: RTL and testbench
=====================================

E203_ITCM_ICB_ARBT -- requirements
Module: e203_itcm_icb_arbt

Interface
REQ-001 Parameter AW, default 16: ITCM byte address width.
REQ-002 Parameter DW, default 64: ITCM data width; wmask width is DW/8.
REQ-003 Parameter OUTS, default 2: maximum outstanding ITCM commands; legal range 1..4.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Ports ifu_cmd_valid in 1, ifu_cmd_ready out 1, ifu_cmd_addr in AW: IFU fetch command; always a read.
REQ-007 Ports ifu_rsp_valid out 1, ifu_rsp_ready in 1, ifu_rsp_err out 1, ifu_rsp_rdata out DW: IFU response.
REQ-008 Ports lsu_cmd_valid in 1, lsu_cmd_ready out 1, lsu_cmd_addr in AW, lsu_cmd_read in 1, lsu_cmd_wdata in DW, lsu_cmd_wmask in DW/8: LSU command.
REQ-009 Ports lsu_rsp_valid out 1, lsu_rsp_ready in 1, lsu_rsp_err out 1, lsu_rsp_rdata out DW: LSU response.
REQ-010 Ports itcm_cmd_valid out 1, itcm_cmd_ready in 1, itcm_cmd_addr out AW, itcm_cmd_read out 1, itcm_cmd_wdata out DW, itcm_cmd_wmask out DW/8: shared ITCM command.
REQ-011 Ports itcm_rsp_valid in 1, itcm_rsp_ready out 1, itcm_rsp_err in 1, itcm_rsp_rdata in DW: shared ITCM response; returns in command order.
REQ-012 Port ifu_holdup, output, 1: the ITCM output register still holds data from the last IFU access.

Function
REQ-013 The block SHALL grant at most one requester per cycle. A command is accepted when its valid and ready are both high.
REQ-014 The block SHALL drive itcm_cmd_valid = (ifu_cmd_valid | lsu_cmd_valid) & ~full, where full = (outstanding count == OUTS).
REQ-015 The block SHALL drive every itcm_cmd_* payload field from the granted requester. IFU grant forces itcm_cmd_read=1, wdata=0 and wmask=0.
REQ-016 The granted requester's cmd_ready SHALL equal itcm_cmd_ready & ~full. The non-granted requester's cmd_ready SHALL be 0.
REQ-017 Grant SHALL be combinational from the current-cycle valids and arbitration state. Zero-cycle latency from cmd to itcm_cmd.
REQ-018 Each accepted itcm command SHALL push its owner ID (0=IFU, 1=LSU) into an OUTS-deep in-order FIFO. Each itcm response handshake SHALL pop it.
REQ-019 The response SHALL be routed to the FIFO-head owner:
  - owner rsp_valid = itcm_rsp_valid
  - owner err/rdata pass through
  - itcm_rsp_ready = owner rsp_ready
  - the other requester's rsp_valid = 0
REQ-020 When the FIFO is empty, all rsp_valid outputs SHALL be 0 and itcm_rsp_ready SHALL be 0.
REQ-021 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-022 When full, no command SHALL be accepted, even if a pop occurs in the same cycle.
REQ-023 FIFO pointers SHALL wrap modulo OUTS.
REQ-024 ifu_holdup SHALL be set on an IFU command accept. It SHALL be cleared on an LSU command accept. Otherwise it holds its value.
REQ-025 An itcm_rsp_valid while the FIFO is empty SHALL be ignored: no pop, no state change. This is a verification assertion.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL reset: FIFO count and pointers to 0, ifu_holdup to 0, round-robin pointer to IFU-preferred.
REQ-027 During reset, all cmd_ready, rsp_valid and itcm_cmd_valid outputs SHALL be 0. Reset SHALL be combinationally gated.
REQ-028 Reset asserted mid-transaction SHALL discard all outstanding ownership. The ITCM is reset on the same rst.

Configuration
REQ-029 With macro E203_ITCM_ARB_RR_EN defined, arbitration SHALL be round-robin:
  - the pointer toggles to the other requester after each accepted command
  - when both requesters are valid, the pointed requester wins.
REQ-030 Without E203_ITCM_ARB_RR_EN, arbitration SHALL be fixed priority with LSU over IFU, and there is no pointer state.

Verification
REQ-031 IFU alone: IFU sends 3 reads at addr 0x0, 0x8, 0x10 and the ITCM responds 1 cycle later each → IFU sees 3 responses in order, ifu_holdup=1 after the first accept, lsu_rsp_valid stays 0.
REQ-032 Backpressure: OUTS=2, itcm_rsp_valid held 0, IFU continuously valid → exactly 2 commands accepted, ifu_cmd_ready=0 on the third cycle; after one rsp pop, the next command is accepted the following cycle.
REQ-033 Contention, fixed priority (macro off): both valid for 4 cycles, itcm_cmd_ready=1, responses immediate → LSU takes all 4 grants and ifu_holdup stays 0.
REQ-034 Contention, round-robin (macro on): both valid for 4 cycles → grants are IFU, LSU, IFU, LSU, and ifu_holdup reads 1,0,1,0 after each accept.
REQ-035 Response routing: IFU cmd then LSU write (wmask=0xFF) accepted, then ITCM err=1 on the first response → ifu_rsp_err=1; the second response goes to the LSU; lsu_rsp_ready=0 stalls itcm_rsp_ready=0.
REQ-036 Reset mid-operation: 2 outstanding, then rst=1 for 1 cycle → count=0, ifu_holdup=0, all valids 0; a post-reset IFU command is accepted normally.

Source files
------------

// File: rtl/e203_itcm_icb_arbt_if.sv
// ITCM arbiter bus bundle: IFU, LSU and shared ITCM ICB channels.
// slave = arbiter side, master = requester/memory side.
interface e203_itcm_icb_arbt_if #(
  parameter int AW = 16,
  parameter int DW = 64
);
  logic          ifu_cmd_valid;
  logic          ifu_cmd_ready;
  logic [AW-1:0] ifu_cmd_addr;
  logic          ifu_rsp_valid;
  logic          ifu_rsp_ready;
  logic          ifu_rsp_err;
  logic [DW-1:0] ifu_rsp_rdata;

  logic            lsu_cmd_valid;
  logic            lsu_cmd_ready;
  logic [AW-1:0]   lsu_cmd_addr;
  logic            lsu_cmd_read;
  logic [DW-1:0]   lsu_cmd_wdata;
  logic [DW/8-1:0] lsu_cmd_wmask;
  logic            lsu_rsp_valid;
  logic            lsu_rsp_ready;
  logic            lsu_rsp_err;
  logic [DW-1:0]   lsu_rsp_rdata;

  logic            itcm_cmd_valid;
  logic            itcm_cmd_ready;
  logic [AW-1:0]   itcm_cmd_addr;
  logic            itcm_cmd_read;
  logic [DW-1:0]   itcm_cmd_wdata;
  logic [DW/8-1:0] itcm_cmd_wmask;
  logic            itcm_rsp_valid;
  logic            itcm_rsp_ready;
  logic            itcm_rsp_err;
  logic [DW-1:0]   itcm_rsp_rdata;

  logic ifu_holdup;

  modport slave (
    input  ifu_cmd_valid, ifu_cmd_addr,
    output ifu_cmd_ready,
    output ifu_rsp_valid, ifu_rsp_err,
    output ifu_rsp_rdata,
    input  ifu_rsp_ready,
    input  lsu_cmd_valid, lsu_cmd_addr,
    input  lsu_cmd_read, lsu_cmd_wdata,
    input  lsu_cmd_wmask,
    output lsu_cmd_ready,
    output lsu_rsp_valid, lsu_rsp_err,
    output lsu_rsp_rdata,
    input  lsu_rsp_ready,
    output itcm_cmd_valid, itcm_cmd_addr,
    output itcm_cmd_read, itcm_cmd_wdata,
    output itcm_cmd_wmask,
    input  itcm_cmd_ready,
    input  itcm_rsp_valid, itcm_rsp_err,
    input  itcm_rsp_rdata,
    output itcm_rsp_ready,
    output ifu_holdup
  );

  modport master (
    output ifu_cmd_valid, ifu_cmd_addr,
    input  ifu_cmd_ready,
    input  ifu_rsp_valid, ifu_rsp_err,
    input  ifu_rsp_rdata,
    output ifu_rsp_ready,
    output lsu_cmd_valid, lsu_cmd_addr,
    output lsu_cmd_read, lsu_cmd_wdata,
    output lsu_cmd_wmask,
    input  lsu_cmd_ready,
    input  lsu_rsp_valid, lsu_rsp_err,
    input  lsu_rsp_rdata,
    output lsu_rsp_ready,
    input  itcm_cmd_valid, itcm_cmd_addr,
    input  itcm_cmd_read, itcm_cmd_wdata,
    input  itcm_cmd_wmask,
    output itcm_cmd_ready,
    output itcm_rsp_valid, itcm_rsp_err,
    output itcm_rsp_rdata,
    input  itcm_rsp_ready,
    input  ifu_holdup
  );
endinterface

// File: rtl/e203_itcm_icb_arbt.sv
// ITCM ICB arbiter: IFU/LSU onto one ITCM port, in-order rsp routing.
// E203_ITCM_ARB_RR_EN selects round-robin; default is LSU-over-IFU.
module e203_itcm_icb_arbt #(
  parameter int AW   = 16,
  parameter int DW   = 64,
  parameter int OUTS = 2
) (
  input logic clk,
  input logic rst,
  e203_itcm_icb_arbt_if.slave bus
);

  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;

  logic [2:0]      cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [OUTS-1:0] own_q, own_d;
  logic            hold_q, hold_d;

  logic full, empty, acc_ok;
  logic gnt_ifu, gnt_lsu;
  logic push, pop, head, rsp_on;

  logic [AW-1:0]   addr_g;
  logic [DW-1:0]   wdata_g;
  logic [DW/8-1:0] wmask_g;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(OUTS-1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == 3'(OUTS));
  assign empty = (cnt_q == 3'd0);

`ifdef E203_ITCM_ARB_RR_EN
  logic rr_q, rr_d;

  assign gnt_lsu = bus.lsu_cmd_valid &
                   (~bus.ifu_cmd_valid | rr_q);
  assign rr_d    = push ? gnt_ifu : rr_q;

  // Pointer aims at the requester not just served.
  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign gnt_lsu = bus.lsu_cmd_valid;
`endif

  assign gnt_ifu = bus.ifu_cmd_valid & ~gnt_lsu;

  assign acc_ok = bus.itcm_cmd_ready & ~full & ~rst;

  assign bus.itcm_cmd_valid =
    (bus.ifu_cmd_valid | bus.lsu_cmd_valid) &
    ~full & ~rst;
  assign bus.ifu_cmd_ready = gnt_ifu & acc_ok;
  assign bus.lsu_cmd_ready = gnt_lsu & acc_ok;

  assign addr_g  = gnt_lsu ? bus.lsu_cmd_addr
                           : bus.ifu_cmd_addr;
  assign wdata_g = gnt_lsu ? bus.lsu_cmd_wdata : '0;
  assign wmask_g = gnt_lsu ? bus.lsu_cmd_wmask : '0;

  assign bus.itcm_cmd_addr  = addr_g;
  assign bus.itcm_cmd_read  = gnt_lsu ? bus.lsu_cmd_read
                                      : 1'b1;
  assign bus.itcm_cmd_wdata = wdata_g;
  assign bus.itcm_cmd_wmask = wmask_g;

  assign push = bus.itcm_cmd_valid & bus.itcm_cmd_ready;

  assign head   = own_q[rptr_q];
  assign rsp_on = bus.itcm_rsp_valid & ~empty & ~rst;

  assign bus.ifu_rsp_valid  = rsp_on & ~head;
  assign bus.lsu_rsp_valid  = rsp_on & head;
  assign bus.itcm_rsp_ready = ~empty & ~rst &
    (head ? bus.lsu_rsp_ready : bus.ifu_rsp_ready);

  assign pop = rsp_on & bus.itcm_rsp_ready;

  assign bus.ifu_rsp_err   = bus.itcm_rsp_err;
  assign bus.ifu_rsp_rdata = bus.itcm_rsp_rdata;
  assign bus.lsu_rsp_err   = bus.itcm_rsp_err;
  assign bus.lsu_rsp_rdata = bus.itcm_rsp_rdata;
  assign bus.ifu_holdup    = hold_q;

  // Next-state for owner FIFO and holdup flag.
  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    own_d  = own_q;
    hold_d = hold_q;
    if (push) begin
      own_d[wptr_q] = gnt_lsu;
      wptr_d        = nxt(wptr_q);
    end
    if (pop) rptr_d = nxt(rptr_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    if (bus.ifu_cmd_valid & bus.ifu_cmd_ready)
      hold_d = 1'b1;
    else if (bus.lsu_cmd_valid & bus.lsu_cmd_ready)
      hold_d = 1'b0;
  end

  // Ownership FIFO and holdup state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      own_q  <= '0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      own_q  <= own_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: tb/tb_e203_itcm_icb_arbt.sv
// Directed bench for e203_itcm_icb_arbt (OUTS=2).
// Inputs change at negedge; checks #1 later or after the next edge.
module tb_e203_itcm_icb_arbt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  e203_itcm_icb_arbt_if #(.AW(16), .DW(64)) bus ();

  e203_itcm_icb_arbt #(
    .AW(16), .DW(64), .OUTS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  logic [3:0] exp_ifu;

  initial begin
    bus.ifu_cmd_valid  = 0; bus.ifu_cmd_addr = '0;
    bus.ifu_rsp_ready  = 1;
    bus.lsu_cmd_valid  = 0; bus.lsu_cmd_addr = '0;
    bus.lsu_cmd_read   = 1; bus.lsu_cmd_wdata = '0;
    bus.lsu_cmd_wmask  = '0; bus.lsu_rsp_ready = 1;
    bus.itcm_cmd_ready = 1; bus.itcm_rsp_valid = 0;
    bus.itcm_rsp_err   = 0; bus.itcm_rsp_rdata = '0;

    // reset gating
    cyc(); cyc();
    bus.ifu_cmd_valid  = 1;
    bus.itcm_rsp_valid = 1;
    #1;
    chk("rst_ifu_rdy", bus.ifu_cmd_ready, 0);
    chk("rst_itcm_vld", bus.itcm_cmd_valid, 0);
    chk("rst_rsp_rdy", bus.itcm_rsp_ready, 0);
    chk("rst_ifu_rspv", bus.ifu_rsp_valid, 0);
    chk("rst_holdup", bus.ifu_holdup, 0);
    cyc();
    rst = 0;
    bus.ifu_cmd_valid  = 0;
    bus.itcm_rsp_valid = 0;

    // IFU alone, 3 reads, 1-cycle responses
    bus.ifu_cmd_valid = 1;
    bus.ifu_cmd_addr  = 16'h0;
    #1;
    chk("t1_rdy0", bus.ifu_cmd_ready, 1);
    chk("t1_vld0", bus.itcm_cmd_valid, 1);
    chk("t1_addr0", bus.itcm_cmd_addr, 16'h0);
    chk("t1_read0", bus.itcm_cmd_read, 1);
    chk("t1_wmask0", bus.itcm_cmd_wmask, 0);
    chk("t1_rspv0", bus.ifu_rsp_valid, 0);
    cyc();
    chk("t1_holdup", bus.ifu_holdup, 1);
    for (int i = 1; i < 4; i++) begin
      bus.ifu_cmd_valid  = (i < 3);
      bus.ifu_cmd_addr   = 16'(i * 8);
      bus.itcm_rsp_valid = 1;
      bus.itcm_rsp_rdata = 64'(i * 32'h1111);
      #1;
      chk("t1_ifu_rspv", bus.ifu_rsp_valid, 1);
      chk("t1_rdata", bus.ifu_rsp_rdata,
          64'(i * 32'h1111));
      chk("t1_lsu_rspv", bus.lsu_rsp_valid, 0);
      chk("t1_rsp_rdy", bus.itcm_rsp_ready, 1);
      if (i < 3) begin
        chk("t1_rdy", bus.ifu_cmd_ready, 1);
        chk("t1_addr", bus.itcm_cmd_addr,
            64'(i * 8));
      end
      cyc();
    end
    // spurious response with FIFO empty
    #1;
    chk("t1_empty_rspv", bus.ifu_rsp_valid, 0);
    chk("t1_empty_rdy", bus.itcm_rsp_ready, 0);
    cyc();
    bus.itcm_rsp_valid = 0;

    // backpressure, OUTS=2
    bus.ifu_cmd_valid = 1;
    #1; chk("t2_rdy1", bus.ifu_cmd_ready, 1);
    cyc();
    #1; chk("t2_rdy2", bus.ifu_cmd_ready, 1);
    cyc();
    bus.itcm_rsp_valid = 1;
    #1;
    chk("t2_full_rdy", bus.ifu_cmd_ready, 0);
    chk("t2_full_vld", bus.itcm_cmd_valid, 0);
    chk("t2_full_pop", bus.itcm_rsp_ready, 1);
    cyc();
    bus.itcm_rsp_valid = 0;
    #1; chk("t2_after_pop", bus.ifu_cmd_ready, 1);
    cyc();
    bus.ifu_cmd_valid = 0;
    bus.itcm_rsp_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1; chk("t2_drain", bus.ifu_rsp_valid, 1);
      cyc();
    end
    #1; chk("t2_drained", bus.itcm_rsp_ready, 0);
    bus.itcm_rsp_valid = 0;

    // response routing: IFU read, LSU write
    bus.ifu_cmd_valid = 1;
    bus.ifu_cmd_addr  = 16'h30;
    #1; chk("t5_ifu_rdy", bus.ifu_cmd_ready, 1);
    cyc();
    bus.ifu_cmd_valid = 0;
    bus.lsu_cmd_valid = 1;
    bus.lsu_cmd_read  = 0;
    bus.lsu_cmd_addr  = 16'h40;
    bus.lsu_cmd_wdata = 64'hDEADBEEF_CAFEF00D;
    bus.lsu_cmd_wmask = 8'hFF;
    #1;
    chk("t5_lsu_rdy", bus.lsu_cmd_ready, 1);
    chk("t5_ifu_nrdy", bus.ifu_cmd_ready, 0);
    chk("t5_read", bus.itcm_cmd_read, 0);
    chk("t5_addr", bus.itcm_cmd_addr, 16'h40);
    chk("t5_wmask", bus.itcm_cmd_wmask, 8'hFF);
    chk("t5_wdata", bus.itcm_cmd_wdata,
        64'hDEADBEEF_CAFEF00D);
    cyc();
    bus.lsu_cmd_valid = 0;
    bus.lsu_cmd_read  = 1;
    bus.itcm_rsp_valid = 1;
    bus.itcm_rsp_err   = 1;
    #1;
    chk("t5_holdup", bus.ifu_holdup, 0);
    chk("t5_ifu_rspv", bus.ifu_rsp_valid, 1);
    chk("t5_ifu_err", bus.ifu_rsp_err, 1);
    chk("t5_lsu_rspv0", bus.lsu_rsp_valid, 0);
    cyc();
    bus.itcm_rsp_err  = 0;
    bus.lsu_rsp_ready = 0;
    #1;
    chk("t5_lsu_rspv", bus.lsu_rsp_valid, 1);
    chk("t5_ifu_rspv0", bus.ifu_rsp_valid, 0);
    chk("t5_stall", bus.itcm_rsp_ready, 0);
    cyc();
    bus.lsu_rsp_ready = 1;
    #1;
    chk("t5_lsu_still", bus.lsu_rsp_valid, 1);
    chk("t5_unstall", bus.itcm_rsp_ready, 1);
    cyc();
    bus.itcm_rsp_valid = 0;

    // reset with 2 outstanding
    bus.ifu_cmd_valid = 1;
    cyc(); cyc();
    rst = 1;
    bus.itcm_rsp_valid = 1;
    #1;
    chk("t6_rst_rdy", bus.ifu_cmd_ready, 0);
    chk("t6_rst_vld", bus.itcm_cmd_valid, 0);
    chk("t6_rst_rspv", bus.ifu_rsp_valid, 0);
    cyc();
    rst = 0;
    bus.ifu_cmd_valid = 0;
    #1;
    chk("t6_holdup", bus.ifu_holdup, 0);
    chk("t6_cnt0_rspv", bus.ifu_rsp_valid, 0);
    chk("t6_cnt0_rdy", bus.itcm_rsp_ready, 0);
    bus.itcm_rsp_valid = 0;
    bus.ifu_cmd_valid  = 1;
    bus.ifu_cmd_addr   = 16'h20;
    #1;
    chk("t6_post_rdy", bus.ifu_cmd_ready, 1);
    cyc();
    bus.ifu_cmd_valid  = 0;
    bus.itcm_rsp_valid = 1;
    #1;
    chk("t6_post_rsp", bus.ifu_rsp_valid, 1);
    chk("t6_post_hold", bus.ifu_holdup, 1);
    cyc();
    bus.itcm_rsp_valid = 0;
    rst = 1;
    cyc();
    rst = 0;

    // contention, both valid 4 cycles
`ifdef E203_ITCM_ARB_RR_EN
    exp_ifu = 4'b0101;
`else
    exp_ifu = 4'b0000;
`endif
    bus.ifu_cmd_valid  = 1;
    bus.ifu_cmd_addr   = 16'h100;
    bus.lsu_cmd_valid  = 1;
    bus.lsu_cmd_addr   = 16'h80;
    bus.itcm_rsp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ifu_rdy", bus.ifu_cmd_ready,
          exp_ifu[i]);
      chk("t3_lsu_rdy", bus.lsu_cmd_ready,
          !exp_ifu[i]);
      chk("t3_addr", bus.itcm_cmd_addr,
          exp_ifu[i] ? 16'h100 : 16'h80);
      if (i > 0)
        chk("t3_lsu_rspv", bus.lsu_rsp_valid,
            !exp_ifu[i-1]);
      cyc();
      chk("t3_holdup", bus.ifu_holdup, exp_ifu[i]);
    end
    bus.ifu_cmd_valid = 0;
    bus.lsu_cmd_valid = 0;
    #1;
    chk("t3_last_rsp", bus.lsu_rsp_valid,
        !exp_ifu[3]);
    cyc();
    bus.itcm_rsp_valid = 0;
    #1;
    chk("t3_idle", bus.itcm_cmd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
